// File: rtl/max7219_pkg.sv
// max7219_pkg: MAX7219 register map and state encodings shared by the frame driver.
package max7219_pkg;
  localparam logic [7:0] REG_DIGIT0    = 8'h01;
  localparam logic [7:0] REG_DECODE    = 8'h09;
  localparam logic [7:0] REG_INTENSITY = 8'h0A;
  localparam logic [7:0] REG_SCANLIM   = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
  localparam logic [7:0] REG_TEST      = 8'h0F;
  localparam int NUM_INIT_WORDS = 5;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_WORD,
    ST_SHIFT_LOW,
    ST_SHIFT_HIGH,
    ST_LATCH
  } shift_state_e;
  typedef enum logic [1:0] {
    FR_IDLE,
    FR_BUSY,
    FR_DONE
  } frame_state_e;
endpackage

// File: rtl/max7219_frame_driver_if.sv
// max7219_frame_driver_if: frame request handshake plus the three-wire MAX7219 bus.
interface max7219_frame_driver_if #(parameter int NUM_DIGITS = 6);
  logic                    i_en;
  logic                    i_start;
  logic [4*NUM_DIGITS-1:0] i_digits;
  logic [NUM_DIGITS-1:0]   i_dp;
  logic                    o_busy;
  logic                    o_done;
  logic                    o_serial_dout;
  logic                    o_serial_load;
  logic                    o_serial_clk;
  modport master (
    output i_en, i_start, i_digits, i_dp,
    input  o_busy, o_done, o_serial_dout, o_serial_load, o_serial_clk
  );
  modport slave (
    input  i_en, i_start, i_digits, i_dp,
    output o_busy, o_done, o_serial_dout, o_serial_load, o_serial_clk
  );
endinterface

// File: rtl/spi_word_shifter.sv
// spi_word_shifter: serialises one 16-bit word MSB first and latches it with a LOAD pulse.
module spi_word_shifter
  import max7219_pkg::*;
#(
  parameter int SCLK_DIV = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        start,
  input  logic [15:0] word,
  output logic        done,
  output logic        sclk,
  output logic        dout,
  output logic        load
);
  localparam int CW = $clog2(2 * SCLK_DIV) + 1;
  localparam logic [CW-1:0] HALF_END  = CW'(SCLK_DIV - 1);
  localparam logic [CW-1:0] HALF      = CW'(SCLK_DIV);
  localparam logic [CW-1:0] LATCH_END = CW'(2 * SCLK_DIV - 1);
  shift_state_e  state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    bitn, bitn_n;
  logic [15:0]   shreg, shreg_n;
  logic          sclk_n, dout_n, load_n;
  // serial pins are registered from next-state so they never glitch
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      bitn  <= '0;
      shreg <= '0;
      sclk  <= 1'b0;
      dout  <= 1'b0;
      load  <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bitn  <= bitn_n;
      shreg <= shreg_n;
      sclk  <= sclk_n;
      dout  <= dout_n;
      load  <= load_n;
    end
  assign done = state == ST_LATCH && cnt == LATCH_END;
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    bitn_n  = bitn;
    shreg_n = shreg;
    unique case (state)
      ST_IDLE: begin
        cnt_n   = '0;
        state_n = start ? ST_LOAD_WORD : ST_IDLE;
      end
      ST_LOAD_WORD: begin
        cnt_n   = '0;
        shreg_n = word;
        bitn_n  = 4'd15;
        state_n = ST_SHIFT_LOW;
      end
      ST_SHIFT_LOW:
        if (cnt == HALF_END) begin
          cnt_n   = '0;
          state_n = ST_SHIFT_HIGH;
        end
      ST_SHIFT_HIGH:
        if (cnt == HALF_END) begin
          cnt_n   = '0;
          shreg_n = {shreg[14:0], 1'b0};
          bitn_n  = bitn - 1'b1;
          state_n = bitn == 4'd0 ? ST_LATCH : ST_SHIFT_LOW;
        end
      ST_LATCH:
        if (done) begin
          cnt_n   = '0;
          state_n = start ? ST_LOAD_WORD : ST_IDLE;
        end
      default: state_n = ST_IDLE;
    endcase
    sclk_n = state_n == ST_SHIFT_HIGH;
    dout_n = (state_n == ST_SHIFT_LOW || state_n == ST_SHIFT_HIGH) && shreg_n[15];
    load_n = !(state_n inside {ST_LOAD_WORD, ST_SHIFT_LOW, ST_SHIFT_HIGH} ||
               (state_n == ST_LATCH && cnt_n < HALF));
  end
endmodule

// File: rtl/max7219_frame_driver.sv
// max7219_frame_driver: sequences init and digit register writes for one display frame.
module max7219_frame_driver
  import max7219_pkg::*;
#(
  parameter int         NUM_DIGITS = 6,
  parameter int         SCLK_DIV   = 4,
  parameter logic [3:0] INTENSITY  = 4'h8
) (
  input logic i_clk,
  input logic i_reset_n,
  max7219_frame_driver_if.slave bus
);
  localparam logic [3:0] LAST_WORD   = 4'(NUM_INIT_WORDS + NUM_DIGITS - 1);
  localparam logic [3:0] FIRST_DIGIT = 4'(NUM_INIT_WORDS);
  localparam logic [7:0] DECODE_MASK = 8'((1 << NUM_DIGITS) - 1);
  localparam logic [7:0] SCAN_LIMIT  = 8'(NUM_DIGITS - 1);
  frame_state_e            fstate, fstate_n;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic                    init_done;
  logic [3:0]              widx, dig_idx;
  logic [3:0]              dig;
  logic                    dp_bit;
  logic [15:0]             word;
  logic                    accept, sh_start, sh_done, last;
  assign accept  = fstate == FR_IDLE && bus.i_en && bus.i_start;
  assign last    = widx == LAST_WORD;
  assign dig_idx = widx - FIRST_DIGIT;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      fstate    <= FR_IDLE;
      digits_q  <= '0;
      dp_q      <= '0;
      widx      <= '0;
      init_done <= 1'b0;
    end else begin
      fstate <= fstate_n;
      if (accept) begin
        digits_q <= bus.i_digits;
        dp_q     <= bus.i_dp;
        widx     <= init_done ? FIRST_DIGIT : 4'd0;
      end else if (fstate == FR_BUSY && sh_done) begin
        widx <= widx + 1'b1;
        if (widx == FIRST_DIGIT - 4'd1) init_done <= 1'b1;
      end
    end
  always_comb begin
    fstate_n = accept ? FR_BUSY :
               fstate == FR_BUSY && sh_done && last ? FR_DONE :
               fstate == FR_DONE ? FR_IDLE : fstate;
    sh_start = accept || (fstate == FR_BUSY && sh_done && !last);
  end
  always_comb begin
    dig    = '0;
    dp_bit = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++)
      if (dig_idx == 4'(d)) begin
        dig    = digits_q[4*d +: 4];
        dp_bit = dp_q[d];
      end
    word = widx == 4'd0 ? {REG_TEST, 8'h00} :
           widx == 4'd1 ? {REG_DECODE, DECODE_MASK} :
           widx == 4'd2 ? {REG_SCANLIM, SCAN_LIMIT} :
           widx == 4'd3 ? {REG_INTENSITY, 4'h0, INTENSITY} :
           widx == 4'd4 ? {REG_SHUTDOWN, 8'h01} :
           {REG_DIGIT0 + {4'h0, dig_idx}, dp_bit, 3'b000, dig};
  end
  assign bus.o_busy = fstate == FR_BUSY;
  assign bus.o_done = fstate == FR_DONE;
  spi_word_shifter #(.SCLK_DIV(SCLK_DIV)) u_shifter (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .start     (sh_start),
    .word      (word),
    .done      (sh_done),
    .sclk      (bus.o_serial_clk),
    .dout      (bus.o_serial_dout),
    .load      (bus.o_serial_load)
  );
endmodule
